// File: rtl/loader_pkg.sv
// Shared state encoding and stream-format constants for the instruction-memory loader.
package loader_pkg;

  localparam int LEN_WIDTH      = 16;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    PAYLOAD,
    WRITE,
    CHECK,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/loader_word_assembler.sv
// Packs four stream bytes into one little-endian word; the first byte of a
// word ends up in bits [7:0] once all four lanes have been shifted in.
module loader_word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic        word_full,
  output logic [31:0] word
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [1:0] lane;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      lane <= '0;
      word <= '0;
    end else if (shift_en) begin
      lane <= lane + 2'd1;
      word <= {byte_in, word[31:8]};
    end
  end

  assign word_full = shift_en && (lane == LAST_LANE);

endmodule

// File: rtl/instruction_memory_loader.sv
// Loads a length-prefixed byte stream into instruction memory as 32-bit words
// while stalling the CPU. Define LOADER_CHECKSUM_EN for a trailing XOR check byte.
module instruction_memory_loader
  import loader_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Start,
  input  logic [7:0]            ByteIn,
  input  logic                  ByteValid,
  output logic                  ByteReady,
  output logic                  WriteEnable,
  output logic [ADDR_WIDTH-1:0] WriteAddress,
  output logic [31:0]           WriteData,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error
);

  localparam logic [LEN_WIDTH-1:0] MAX_N = LEN_WIDTH'(MAX_WORDS);

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t AFTER_PAYLOAD = CHECK;
`else
  localparam loader_state_t AFTER_PAYLOAD = DONE;
`endif

  loader_state_t        state;
  loader_state_t        state_next;
  logic [7:0]           len_lo;
  logic [LEN_WIDTH-1:0] n_words;
  logic [LEN_WIDTH-1:0] idx;
  logic [LEN_WIDTH-1:0] n_hdr;
  logic                 xfer;
  logic                 start_ok;
  logic                 word_full;
  logic [31:0]          word;

  assign xfer     = ByteValid && ByteReady;
  assign start_ok = Start && (state == IDLE || state == DONE || state == ERR);
  assign n_hdr    = {ByteIn, len_lo};

  loader_word_assembler u_assembler (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_ok),
    .shift_en  (xfer && (state == PAYLOAD)),
    .byte_in   (ByteIn),
    .word_full (word_full),
    .word      (word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      len_lo  <= '0;
      n_words <= '0;
      idx     <= '0;
    end else begin
      state <= state_next;
      if (start_ok) idx <= '0;
      if (state == LEN_LO && xfer) len_lo <= ByteIn;
      if (state == LEN_HI && xfer) n_words <= n_hdr;
      if (state == WRITE) idx <= idx + LEN_WIDTH'(1);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] xsum;

  // Running XOR of payload bytes only; the length header is excluded.
  always_ff @(posedge clk) begin
    if (!rst_n || start_ok) xsum <= '0;
    else if (state == PAYLOAD && xfer) xsum <= xsum ^ ByteIn;
  end
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERR: if (start_ok) state_next = LEN_LO;
      LEN_LO:          if (xfer) state_next = LEN_HI;
      LEN_HI: begin
        if (xfer) begin
          if (n_hdr == '0)       state_next = AFTER_PAYLOAD;
          else if (n_hdr > MAX_N) state_next = ERR;
          else                   state_next = PAYLOAD;
        end
      end
      PAYLOAD:         if (word_full) state_next = WRITE;
      WRITE: begin
        if (idx + LEN_WIDTH'(1) == n_words) state_next = AFTER_PAYLOAD;
        else                                state_next = PAYLOAD;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK:           if (xfer) state_next = (ByteIn == xsum) ? DONE : ERR;
`endif
      default:         state_next = IDLE;
    endcase
  end

  always_comb begin
    ByteReady   = 1'b0;
    WriteEnable = 1'b0;
    Busy        = 1'b0;
    Done        = 1'b0;
    Error       = 1'b0;
    case (state)
      LEN_LO, LEN_HI, PAYLOAD, CHECK: begin
        ByteReady = 1'b1;
        Busy      = 1'b1;
      end
      WRITE: begin
        WriteEnable = 1'b1;
        Busy        = 1'b1;
      end
      DONE:    Done  = 1'b1;
      ERR:     Error = 1'b1;
      default: ;
    endcase
  end

  // idx never exceeds MAX_WORDS, so the address cannot wrap.
  assign WriteAddress = BASE_ADDR + ADDR_WIDTH'({idx, 2'b00});
  assign WriteData    = word;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Randomized bench for instruction_memory_loader against a stream-level model;
// compile with LOADER_CHECKSUM_EN to also exercise the trailing check byte.
module tb_instruction_memory_loader;

  localparam int          ADDR_WIDTH = 32;
  localparam logic [31:0] BASE       = 32'h0;
  localparam int          MAXW       = 256;

  logic                  clk       = 1'b0;
  logic                  rst_n     = 1'b0;
  logic                  Start     = 1'b0;
  logic [7:0]            ByteIn    = 8'h00;
  logic                  ByteValid = 1'b0;
  logic                  ByteReady;
  logic                  WriteEnable;
  logic [ADDR_WIDTH-1:0] WriteAddress;
  logic [31:0]           WriteData;
  logic                  Busy;
  logic                  Done;
  logic                  Error;

  instruction_memory_loader #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE),
    .MAX_WORDS  (MAXW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Start        (Start),
    .ByteIn       (ByteIn),
    .ByteValid    (ByteValid),
    .ByteReady    (ByteReady),
    .WriteEnable  (WriteEnable),
    .WriteAddress (WriteAddress),
    .WriteData    (WriteData),
    .Busy         (Busy),
    .Done         (Done),
    .Error        (Error)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  stim[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] mem [0:MAXW-1];
  bit          exp_done = 1'b0;
  bit          exp_err = 1'b0;
  int          cur_n = 0;
  int          exp_writes = 0;
  bit          real_start = 1'b0;
  int          xfer_cnt = 0;
  int          write_count = 0;
  bit          exp_we_next = 1'b0;
  bit          last_next = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Cycle-level observer: write timing follows from the count of bytes transferred.
  always @(negedge clk) begin
    logic [31:0] ea;
    logic [31:0] ed;
    logic [7:0]  mi;
    bit          was_last;
    if (!rst_n) begin
      xfer_cnt    = 0;
      exp_we_next = 1'b0;
      last_next   = 1'b0;
    end else begin
      was_last = 1'b0;
      if (exp_we_next || WriteEnable)
        checkOutput("write_timing", 32'(WriteEnable), 32'(exp_we_next));
      if (WriteEnable) begin
        write_count++;
        checkOutput("ready_during_write", 32'(ByteReady), 32'h0);
        if (exp_addr_q.size() == 0) begin
          checkOutput("unexpected_write_count", 32'(write_count), 32'(exp_writes));
        end else begin
          ea = exp_addr_q.pop_front();
          ed = exp_data_q.pop_front();
          checkOutput("write_addr", WriteAddress, ea);
          checkOutput("write_data", WriteData, ed);
          mi = 8'((WriteAddress - BASE) >> 2);
          mem[mi] = WriteData;
          was_last = (exp_addr_q.size() == 0);
        end
      end
      if (last_next) begin
`ifdef LOADER_CHECKSUM_EN
        checkOutput("check_state_after_last", 32'({Busy, ByteReady, Done}), 32'b110);
`else
        checkOutput("done_after_last", 32'({Busy, Done}), 32'b01);
`endif
      end
      last_next = was_last;
      checkOutput("status_consistent",
                  32'((Busy && (Done || Error)) || (Done && Error) || (ByteReady && !Busy)), 32'h0);
      exp_we_next = 1'b0;
      if (Start && real_start) begin
        xfer_cnt    = 0;
        write_count = 0;
      end else if (ByteValid && ByteReady) begin
        if (xfer_cnt >= 2 && xfer_cnt < 2 + 4 * cur_n && (xfer_cnt - 2) % 4 == 3)
          exp_we_next = 1'b1;
        xfer_cnt++;
      end
    end
  end

  task automatic addCheck();
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 2; i < stim.size(); i++) x ^= stim[i];
    stim.push_back(x);
`endif
  endtask

  task automatic makeStream(input int n);
    stim.delete();
    stim.push_back(8'(n));
    stim.push_back(8'(n >> 8));
    if (n <= MAXW) begin
      for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom));
      addCheck();
    end
  endtask

  task automatic setN2();
    stim.delete();
    stim.push_back(8'h02); stim.push_back(8'h00);
    stim.push_back(8'h78); stim.push_back(8'h56); stim.push_back(8'h34); stim.push_back(8'h12);
    stim.push_back(8'hEF); stim.push_back(8'hBE); stim.push_back(8'hAD); stim.push_back(8'hDE);
    addCheck();
  endtask

  // Reference model: expected writes and final status straight from the stream bytes.
  task automatic buildExpect();
    int          n;
    logic [31:0] w;
    exp_addr_q.delete();
    exp_data_q.delete();
    n          = int'(stim[0]) + 256 * int'(stim[1]);
    cur_n      = n;
    exp_writes = 0;
    if (n > MAXW) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) begin
        w = 32'h0;
        for (int b = 0; b < 4; b++) w = w + (32'(stim[2 + 4 * i + b]) << (8 * b));
        exp_addr_q.push_back(BASE + 32'(4 * i));
        exp_data_q.push_back(w);
      end
      exp_writes = n;
`ifdef LOADER_CHECKSUM_EN
      begin
        logic [7:0] x;
        x = 8'h00;
        for (int k = 2; k < 2 + 4 * n; k++) x ^= stim[k];
        exp_done = (stim[2 + 4 * n] == x);
        exp_err  = !exp_done;
      end
`else
      exp_done = 1'b1;
      exp_err  = 1'b0;
`endif
    end
  endtask

  task automatic applyStimulus(input int pct, input bit toggle, input bit midstart, input int limit);
    int lim;
    int k;
    int cyc;
    bit did;
    bit took;
    lim = (limit < 0) ? stim.size() : limit;
    @(posedge clk); #1;
    Start = 1'b1; real_start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; real_start = 1'b0;
    k = 0; cyc = 0; did = 1'b0;
    while (k < lim) begin
      ByteIn = stim[k];
      if (toggle) ByteValid = (cyc % 2 == 0);
      else        ByteValid = ($urandom_range(99) < pct);
      if (midstart && !did && k == 4) begin
        Start = 1'b1;
        did   = 1'b1;
      end
      @(negedge clk);
      took = ByteValid && ByteReady;
      @(posedge clk); #1;
      Start = 1'b0;
      if (took) k++;
      cyc++;
      if (cyc > 20000) begin
        checkOutput("byte_budget", 32'(k), 32'(lim));
        break;
      end
    end
    ByteValid = 1'b0;
  endtask

  task automatic waitEnd(input string tag);
    int c;
    c = 0;
    @(negedge clk);
    while (!(Done || Error) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    checkOutput({tag, "_done"}, 32'(Done), 32'(exp_done));
    checkOutput({tag, "_error"}, 32'(Error), 32'(exp_err));
    checkOutput({tag, "_busy"}, 32'(Busy), 32'h0);
    checkOutput({tag, "_pending"}, 32'(exp_addr_q.size()), 32'h0);
    checkOutput({tag, "_writes"}, 32'(write_count), 32'(exp_writes));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ctrl"}, 32'({ByteReady, WriteEnable, Busy, Done, Error}), 32'h0);
    checkOutput({tag, "_addr"}, WriteAddress, BASE);
    checkOutput({tag, "_data"}, WriteData, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetValues("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    ByteValid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      ByteIn = 8'($urandom);
      @(negedge clk);
      checkOutput("idle_no_accept", 32'({ByteReady, WriteEnable, Busy}), 32'h0);
      @(posedge clk); #1;
    end
    ByteValid = 1'b0;

    setN2();
    buildExpect();
    checkOutput("model_word0", exp_data_q[0], 32'h12345678);
    checkOutput("model_word1", exp_data_q[1], 32'hDEADBEEF);
    checkOutput("model_addr1", exp_addr_q[1], 32'h4);
    mem[0] = 32'h0; mem[1] = 32'h0;
    applyStimulus(100, 1'b0, 1'b0, -1);
    waitEnd("n2");
    checkOutput("readback0", mem[0], 32'h12345678);
    checkOutput("readback1", mem[1], 32'hDEADBEEF);

    setN2();
    buildExpect();
    mem[0] = 32'h0; mem[1] = 32'h0;
    applyStimulus(100, 1'b1, 1'b0, -1);
    waitEnd("toggle");
    checkOutput("toggle_readback0", mem[0], 32'h12345678);
    checkOutput("toggle_readback1", mem[1], 32'hDEADBEEF);

    makeStream(0);
    buildExpect();
    applyStimulus(100, 1'b0, 1'b0, -1);
    waitEnd("n0");

    makeStream(MAXW + 1);
    buildExpect();
    applyStimulus(100, 1'b0, 1'b0, -1);
    waitEnd("n257");

    makeStream(MAXW);
    buildExpect();
    applyStimulus(100, 1'b0, 1'b0, -1);
    waitEnd("n256");

    makeStream(4);
    buildExpect();
    applyStimulus(100, 1'b0, 1'b0, 8);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetValues("midreset");
    checkOutput("midreset_writes", 32'(write_count), 32'h1);
    exp_addr_q.delete();
    exp_data_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    setN2();
    buildExpect();
    applyStimulus(100, 1'b0, 1'b0, -1);
    waitEnd("reload");

    for (int r = 0; r < 10; r++) begin
      makeStream(int'($urandom_range(8, 1)));
`ifdef LOADER_CHECKSUM_EN
      if ($urandom_range(1) == 1) stim[stim.size() - 1] ^= 8'h01;
`endif
      buildExpect();
      applyStimulus(int'($urandom_range(100, 30)), 1'b0, 1'($urandom_range(1)), -1);
      waitEnd("random");
    end

`ifdef LOADER_CHECKSUM_EN
    stim.delete();
    stim.push_back(8'h01); stim.push_back(8'h00);
    stim.push_back(8'h01); stim.push_back(8'h02); stim.push_back(8'h04); stim.push_back(8'h08);
    stim.push_back(8'h0F);
    buildExpect();
    checkOutput("model_check_ok", 32'(exp_done), 32'h1);
    applyStimulus(100, 1'b0, 1'b0, -1);
    waitEnd("chk_ok");
    stim[6] = 8'h0E;
    buildExpect();
    checkOutput("model_check_bad", 32'(exp_err), 32'h1);
    mem[0] = 32'h0;
    applyStimulus(100, 1'b0, 1'b0, -1);
    waitEnd("chk_bad");
    checkOutput("chk_bad_word", mem[0], 32'h08040201);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
